// File: rtl/route_request.sv
// route_request: takes one Ethernet header at a time, asks the routing table
// for the destination port mask, strips the ingress port from the answer and
// presents the routed header downstream. A lookup that the table never
// answers falls back to DEFAULT_PORT after 2^LGTIMEOUT-1 cycles. A header
// whose final mask is empty is dropped.
module route_request #(
    parameter int              NETH         = 4,
    parameter int              MACW         = 48,
    parameter logic [NETH-1:0] DEFAULT_PORT = {NETH{1'b1}},
    parameter int              LGTIMEOUT    = 4,
    parameter logic            OPT_LOWPOWER = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            S_VALID,
    output logic            S_READY,
    input  logic [MACW-1:0] S_DSTMAC,
    input  logic [NETH-1:0] S_SRCPORT,
    output logic            TBL_VALID,
    input  logic            TBL_ACK,
    output logic [MACW-1:0] TBL_DSTMAC,
    input  logic [NETH-1:0] TBL_PORT,
    output logic            M_VALID,
    input  logic            M_READY,
    output logic [MACW-1:0] M_DSTMAC,
    output logic [NETH-1:0] M_PORT,
    output logic            o_drop,
    output logic            o_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [LGTIMEOUT-1:0] CNT_MAX  = {LGTIMEOUT{1'b1}};
    localparam logic [LGTIMEOUT-1:0] CNT_ONE  = {{(LGTIMEOUT-1){1'b0}}, 1'b1};
    localparam logic [LGTIMEOUT-1:0] CNT_ZERO = {LGTIMEOUT{1'b0}};

    state_t               state_q, state_d;
    logic                 s_ready_q, s_ready_d;
    logic                 tbl_valid_q, tbl_valid_d;
    logic [MACW-1:0]      tbl_dstmac_q, tbl_dstmac_d;
    logic [NETH-1:0]      srcport_q, srcport_d;
    logic [LGTIMEOUT-1:0] cnt_q, cnt_d;
    logic                 m_valid_q, m_valid_d;
    logic [MACW-1:0]      m_dstmac_q, m_dstmac_d;
    logic [NETH-1:0]      m_port_q, m_port_d;
    logic                 drop_q, drop_d;
    logic                 timeout_q, timeout_d;
    logic                 decide_s;
    logic [NETH-1:0]      mask_s;

    // Next-state and next-output computation for the header pipeline.
    always_comb begin
        state_d      = state_q;
        s_ready_d    = s_ready_q;
        tbl_valid_d  = tbl_valid_q;
        tbl_dstmac_d = tbl_dstmac_q;
        srcport_d    = srcport_q;
        cnt_d        = cnt_q;
        m_valid_d    = m_valid_q;
        m_dstmac_d   = m_dstmac_q;
        m_port_d     = m_port_q;
        drop_d       = 1'b0;
        timeout_d    = 1'b0;
        decide_s     = 1'b0;
        mask_s       = {NETH{1'b0}};

        case (state_q)
            IDLE: begin
                if (S_VALID && s_ready_q) begin
                    tbl_dstmac_d = S_DSTMAC;
                    srcport_d    = S_SRCPORT;
                    cnt_d        = CNT_MAX;
                    tbl_valid_d  = 1'b1;
                    s_ready_d    = 1'b0;
                    state_d      = LOOKUP;
                end else begin
                    s_ready_d    = 1'b1;
                end
            end
            LOOKUP: begin
                // A table answer on the final cycle still beats the timeout.
                if (TBL_ACK) begin
                    decide_s = 1'b1;
                    mask_s   = TBL_PORT & ~srcport_q;
                end else if (cnt_q <= CNT_ONE) begin
                    decide_s  = 1'b1;
                    mask_s    = DEFAULT_PORT & ~srcport_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end

                if (decide_s) begin
                    cnt_d       = CNT_ZERO;
                    tbl_valid_d = 1'b0;
                    if (OPT_LOWPOWER) begin
                        tbl_dstmac_d = {MACW{1'b0}};
                    end else begin
                        tbl_dstmac_d = tbl_dstmac_q;
                    end
                    if (mask_s != {NETH{1'b0}}) begin
                        m_valid_d  = 1'b1;
                        m_port_d   = mask_s;
                        m_dstmac_d = tbl_dstmac_q;
                        state_d    = HOLD;
                    end else begin
                        drop_d    = 1'b1;
                        s_ready_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    state_d = LOOKUP;
                end
            end
            HOLD: begin
                if (M_READY) begin
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    state_d   = IDLE;
                    if (OPT_LOWPOWER) begin
                        m_dstmac_d = {MACW{1'b0}};
                        m_port_d   = {NETH{1'b0}};
                    end else begin
                        m_dstmac_d = m_dstmac_q;
                        m_port_d   = m_port_q;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d     = IDLE;
                s_ready_d   = 1'b0;
                tbl_valid_d = 1'b0;
                m_valid_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any header silently.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            s_ready_q    <= 1'b0;
            tbl_valid_q  <= 1'b0;
            tbl_dstmac_q <= {MACW{1'b0}};
            srcport_q    <= {NETH{1'b0}};
            cnt_q        <= CNT_ZERO;
            m_valid_q    <= 1'b0;
            m_dstmac_q   <= {MACW{1'b0}};
            m_port_q     <= {NETH{1'b0}};
            drop_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_ready_q    <= s_ready_d;
            tbl_valid_q  <= tbl_valid_d;
            tbl_dstmac_q <= tbl_dstmac_d;
            srcport_q    <= srcport_d;
            cnt_q        <= cnt_d;
            m_valid_q    <= m_valid_d;
            m_dstmac_q   <= m_dstmac_d;
            m_port_q     <= m_port_d;
            drop_q       <= drop_d;
            timeout_q    <= timeout_d;
        end
    end

    assign S_READY    = s_ready_q;
    assign TBL_VALID  = tbl_valid_q;
    assign TBL_DSTMAC = tbl_dstmac_q;
    assign M_VALID    = m_valid_q;
    assign M_DSTMAC   = m_dstmac_q;
    assign M_PORT     = m_port_q;
    assign o_drop     = drop_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_route_request.sv
// Directed bench for route_request: a vector table of single-header
// transactions plus hand-written reset and back-to-back sequences.
module tb_route_request;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [47:0] s_dstmac;
    logic [3:0]  s_srcport;
    logic        tbl_valid;
    logic        tbl_ack;
    logic [47:0] tbl_dstmac;
    logic [3:0]  tbl_port;
    logic        m_valid;
    logic        m_ready;
    logic [47:0] m_dstmac;
    logic [3:0]  m_port;
    logic        o_drop;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;

    route_request dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .S_VALID    (s_valid),
        .S_READY    (s_ready),
        .S_DSTMAC   (s_dstmac),
        .S_SRCPORT  (s_srcport),
        .TBL_VALID  (tbl_valid),
        .TBL_ACK    (tbl_ack),
        .TBL_DSTMAC (tbl_dstmac),
        .TBL_PORT   (tbl_port),
        .M_VALID    (m_valid),
        .M_READY    (m_ready),
        .M_DSTMAC   (m_dstmac),
        .M_PORT     (m_port),
        .o_drop     (o_drop),
        .o_timeout  (o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] mac;
        logic [3:0]  src;
        int          ack_wait;   // LOOKUP cycle index carrying the ACK, 255 = never
        logic [3:0]  tport;
        int          exp_lk;     // LOOKUP cycles TBL_VALID stays high
        logic [3:0]  exp_port;
        logic        exp_drop;
        logic        exp_tout;
        int          hold;       // cycles M_READY is held low
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  lk;
        bit  done;
        int  guard;
        guard = 0;
        while (!s_ready && guard < 10) begin
            step();
            guard++;
        end
        chk($sformatf("v%0d ready_before", idx), 64'(s_ready), 64'(1'b1));

        s_valid   = 1'b1;
        s_dstmac  = v.mac;
        s_srcport = v.src;
        step();
        s_valid   = 1'b0;
        s_dstmac  = 48'h0;
        chk($sformatf("v%0d tbl_valid", idx), 64'(tbl_valid), 64'(1'b1));
        chk($sformatf("v%0d tbl_dstmac", idx), 64'(tbl_dstmac), 64'(v.mac));
        chk($sformatf("v%0d s_ready_busy", idx), 64'(s_ready), 64'(1'b0));

        lk   = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tbl_ack  = (c == v.ack_wait);
            tbl_port = v.tport;
            step();
            tbl_ack  = 1'b0;
            lk++;
            if (!tbl_valid) done = 1'b1;
        end
        chk($sformatf("v%0d lookup_cycles", idx), 64'(lk), 64'(v.exp_lk));
        chk($sformatf("v%0d o_timeout", idx), 64'(o_timeout), 64'(v.exp_tout));
        chk($sformatf("v%0d o_drop", idx), 64'(o_drop), 64'(v.exp_drop));

        if (v.exp_drop) begin
            chk($sformatf("v%0d m_valid_drop", idx), 64'(m_valid), 64'(1'b0));
            chk($sformatf("v%0d s_ready_drop", idx), 64'(s_ready), 64'(1'b1));
            step();
            chk($sformatf("v%0d drop_pulse", idx), 64'(o_drop), 64'(1'b0));
            chk($sformatf("v%0d tout_pulse", idx), 64'(o_timeout), 64'(1'b0));
        end else begin
            chk($sformatf("v%0d m_valid", idx), 64'(m_valid), 64'(1'b1));
            chk($sformatf("v%0d m_port", idx), 64'(m_port), 64'(v.exp_port));
            chk($sformatf("v%0d m_dstmac", idx), 64'(m_dstmac), 64'(v.mac));
            chk($sformatf("v%0d s_ready_hold", idx), 64'(s_ready), 64'(1'b0));
            for (int h = 0; h < v.hold; h++) begin
                m_ready = 1'b0;
                tbl_ack = 1'b1;       // spurious: must be ignored while holding
                tbl_port = 4'b1111;
                step();
                chk($sformatf("v%0d hold%0d m_valid", idx, h), 64'(m_valid), 64'(1'b1));
                chk($sformatf("v%0d hold%0d m_port", idx, h), 64'(m_port), 64'(v.exp_port));
                chk($sformatf("v%0d hold%0d m_dstmac", idx, h), 64'(m_dstmac), 64'(v.mac));
                chk($sformatf("v%0d hold%0d s_ready", idx, h), 64'(s_ready), 64'(1'b0));
                chk($sformatf("v%0d hold%0d tbl_valid", idx, h), 64'(tbl_valid), 64'(1'b0));
                chk($sformatf("v%0d hold%0d o_timeout", idx, h), 64'(o_timeout), 64'(1'b0));
            end
            tbl_ack = 1'b0;
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
            chk($sformatf("v%0d m_valid_done", idx), 64'(m_valid), 64'(1'b0));
            chk($sformatf("v%0d s_ready_done", idx), 64'(s_ready), 64'(1'b1));
        end
    endtask

    initial begin
        int  accepts;
        int  last_acc;
        bit  prev_tv;
        bit  prev_ack;

        vecs[0] = '{48'h0200_0000_0001, 4'b0001, 1,   4'b0100, 2,  4'b0100, 1'b0, 1'b0, 0};
        vecs[1] = '{48'h0200_0000_0002, 4'b0010, 1,   4'b0010, 2,  4'b0000, 1'b1, 1'b0, 0};
        vecs[2] = '{48'h0200_0000_0003, 4'b0001, 255, 4'b0000, 15, 4'b1110, 1'b0, 1'b1, 0};
        vecs[3] = '{48'hA1B2_C3D4_E5F6, 4'b0100, 14,  4'b1111, 15, 4'b1011, 1'b0, 1'b0, 10};
        vecs[4] = '{48'h0000_0000_00FF, 4'b1000, 0,   4'b0111, 1,  4'b0111, 1'b0, 1'b0, 0};
        vecs[5] = '{48'h1234_5678_9ABC, 4'b0001, 3,   4'b0001, 4,  4'b0000, 1'b1, 1'b0, 0};
        vecs[6] = '{48'hFFFF_FFFF_FFFE, 4'b1000, 13,  4'b1001, 14, 4'b0001, 1'b0, 1'b0, 2};
        vecs[7] = '{48'h0200_0000_0007, 4'b1111, 255, 4'b0000, 15, 4'b0000, 1'b1, 1'b1, 0};

        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_dstmac  = 48'h0;
        s_srcport = 4'b0000;
        tbl_ack   = 1'b0;
        tbl_port  = 4'b0000;
        m_ready   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst s_ready", 64'(s_ready), 64'(1'b0));
        chk("rst tbl_valid", 64'(tbl_valid), 64'(1'b0));
        chk("rst m_valid", 64'(m_valid), 64'(1'b0));
        chk("rst m_port", 64'(m_port), 64'(4'b0000));
        chk("rst m_dstmac", 64'(m_dstmac), 64'(48'h0));
        chk("rst tbl_dstmac", 64'(tbl_dstmac), 64'(48'h0));
        chk("rst o_drop", 64'(o_drop), 64'(1'b0));
        chk("rst o_timeout", 64'(o_timeout), 64'(1'b0));
        rst_n = 1'b1;
        step();
        chk("rst release s_ready", 64'(s_ready), 64'(1'b1));

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of a lookup: everything clears without a pulse
        s_valid   = 1'b1;
        s_dstmac  = 48'hDEAD_BEEF_0001;
        s_srcport = 4'b0010;
        step();
        s_valid = 1'b0;
        step();
        chk("midrst in_lookup", 64'(tbl_valid), 64'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("midrst tbl_valid", 64'(tbl_valid), 64'(1'b0));
        chk("midrst tbl_dstmac", 64'(tbl_dstmac), 64'(48'h0));
        chk("midrst m_port", 64'(m_port), 64'(4'b0000));
        chk("midrst m_dstmac", 64'(m_dstmac), 64'(48'h0));
        chk("midrst s_ready", 64'(s_ready), 64'(1'b0));
        chk("midrst m_valid", 64'(m_valid), 64'(1'b0));
        step();
        rst_n = 1'b1;
        step();
        chk("midrst s_ready_after", 64'(s_ready), 64'(1'b1));
        tbl_ack  = 1'b1;
        tbl_port = 4'b1111;
        step();
        tbl_ack = 1'b0;
        chk("spurious m_valid", 64'(m_valid), 64'(1'b0));
        chk("spurious tbl_valid", 64'(tbl_valid), 64'(1'b0));
        chk("spurious o_drop", 64'(o_drop), 64'(1'b0));
        chk("spurious o_timeout", 64'(o_timeout), 64'(1'b0));
        chk("spurious s_ready", 64'(s_ready), 64'(1'b1));

        // Back-to-back headers, table answers one cycle after each request
        s_valid   = 1'b1;
        s_dstmac  = 48'h0200_0000_00AA;
        s_srcport = 4'b0001;
        tbl_port  = 4'b0110;
        m_ready   = 1'b1;
        accepts   = 0;
        last_acc  = -1;
        prev_tv   = 1'b0;
        prev_ack  = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (prev_ack) begin
                chk($sformatf("b2b c%0d tbl_valid_after_ack", c), 64'(tbl_valid), 64'(1'b0));
            end
            if (s_ready) begin
                if (last_acc >= 0) begin
                    chk($sformatf("b2b c%0d spacing", c), 64'(c - last_acc), 64'(4));
                end
                last_acc = c;
                accepts++;
            end
            tbl_ack  = tbl_valid && prev_tv && !prev_ack;
            prev_ack = tbl_ack;
            prev_tv  = tbl_valid;
            step();
        end
        s_valid = 1'b0;
        tbl_ack = 1'b0;
        chk("b2b accepts", 64'(accepts), 64'(6));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
